ysyx_041461_lsu: RTL and testbench
==================================

# ysyx_041461_lsu

MEM-stage load/store unit: consumes the address, store data and MEM control code delivered by the EXE→MEM pipeline register and carries out the access on the data bus using a valid/ready request and a valid response. It holds the pipeline through `lsu_stall_out`, which drives the MEM register's enable low, until the access completes. It then returns aligned, extended load data to writeback.

## Interface
Parameters:
- none; bus widths fixed at 64-bit data, 64-bit address, 8-bit byte mask.

Ports:
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `lsu_valid_in`  in  1  MEM stage holds a valid instruction.
- `lsu_ctrl_in`  in  4  MEM control code.
- `lsu_addr_in`  in  64  effective address (EXE result).
- `lsu_wdata_in`  in  64  store data (rs2 value, LSB-justified).
- `lsu_stall_out`  out  1  hold the pipeline (combinational).
- `lsu_done_out`  out  1  one-cycle completion pulse.
- `lsu_rdata_out`  out  64  extended load result; valid while `lsu_done_out`.
- `lsu_misalign_out`  out  1  completed access was misaligned; valid while `lsu_done_out`.
- `mem_req_valid`  out  1  bus request valid.
- `mem_req_ready`  in  1  bus accepts request.
- `mem_req_addr`  out  64  request address, `{addr[63:3],3'b0}`.
- `mem_req_wen`  out  1  1 = store.
- `mem_req_wdata`  out  64  lane-shifted store data.
- `mem_req_wmask`  out  8  byte strobes.
- `mem_resp_valid`  in  1  response/write-ack valid.
- `mem_resp_rdata`  in  64  aligned 64-bit read data.

## Operation
- Ctrl codes:
  - NOP = 0, LB = 1, LH = 2, LW = 3, LD = 4, LBU = 5, LHU = 6, LWU = 7.
  - SB = 8, SH = 9, SW = A, SD = B.
  - C–F are reserved and treated as NOP.
- "Mem op" means `lsu_valid_in` is high and the ctrl code is between 1 and B.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE:
  - On a mem op, latch ctrl, addr and wdata.
  - If the address is not naturally aligned for its size (H: `addr[0]`; W: `addr[1:0]`; D: `addr[2:0]`), go to DONE with misalign set. No bus request is issued.
  - Otherwise go to REQ.
- REQ:
  - `mem_req_valid` = 1; addr, wen, wdata and wmask are driven from the latched values and held stable.
  - On `mem_req_ready`, go to WAIT.
- WAIT:
  - On `mem_resp_valid`, capture the extended read data and go to DONE.
  - Stores also wait for `mem_resp_valid`, which acts as the write ack.
- DONE:
  - `lsu_done_out` = 1 and stall = 0, so the pipeline advances this edge.
  - Next state is always IDLE.
- Stall: `lsu_stall_out` = mem op AND state ≠ DONE.
  - NOP and invalid instructions never stall.
- Store lanes, with `off = addr[2:0]`:
  - `wdata = wdata_in << (8*off)`.
  - `wmask = {1,3,F,FF}[size] << off`.
- Load extract:
  - `d = resp_rdata >> (8*off)`.
  - Truncate `d` to the access size.
  - Sign-extend for LB/LH/LW; zero-extend for LBU/LHU/LWU/LD.
- Misaligned completion: `lsu_rdata_out` = 0.

## Timing
- Reset (async, `rst` = 0):
  - State goes to IDLE.
  - `mem_req_valid`, `lsu_done_out`, `lsu_misalign_out` = 0.
  - `lsu_rdata_out`, `mem_req_addr`, `mem_req_wdata` = 0; `mem_req_wmask`, `mem_req_wen` = 0.
- Reset mid-transaction abandons the request. A response arriving later is ignored, because it is only accepted in WAIT.
- Best-case aligned access (ready high in REQ, response the following cycle):
  - cycle 0: IDLE.
  - cycle 1: REQ.
  - cycle 2: WAIT + resp.
  - cycle 3: DONE.
  - Stall is high for cycles 0–2.
- Misaligned access: cycle 0 IDLE, cycle 1 DONE.
- Bus rules:
  - `mem_resp_valid` in REQ or IDLE is ignored.
  - The earliest accepted response is the cycle after the handshake.
  - `mem_req_valid` never drops before ready.
- Back-to-back mem ops: the second op is seen in the IDLE cycle after DONE, giving one bubble. Stall is asserted again combinationally in that cycle.
- Inputs change only when stall is low; the latched copies make the bus outputs independent of upstream after IDLE.

## Structure
- Shared defines file holds:
  - the `ysyx_041461_MEM_*` ctrl encodings listed above (MEM_NOP = 0);
  - the LSU state encodings (IDLE = 0, REQ = 1, WAIT = 2, DONE = 3).
- Sub-module `ysyx_041461_lsu_align`, combinational:
  - store lane shift and mask generation;
  - load shift and extension from ctrl and `off`.
- The top level contains the FSM, latches and output registers.

## Test plan
- LD, addr 0x8000_0010, ready = 1, resp next cycle with 0x1122334455667788:
  - done in cycle 3; rdata = 0x1122334455667788;
  - `mem_req_addr` = 0x8000_0010; stall high for exactly 3 cycles.
- LB, addr 0x8000_0007, rdata 0x80xx_xxxx_xxxx_xxxx → rdata_out = 0xFFFF_FFFF_FFFF_FF80. The same access with LBU → 0x80.
- SH, addr 0x8000_0002, wdata_in 0xABCD:
  - `mem_req_wdata` = 0x0000_0000_ABCD_0000, wmask = 0x0C, wen = 1;
  - ready withheld 4 cycles → request fields stable throughout.
- LW at addr 0x8000_0006:
  - no `mem_req_valid`; done in cycle 1;
  - misalign = 1, rdata = 0.
- Reset asserted while in WAIT, then a response pulses after reset release → state IDLE, no `lsu_done_out`, all outputs 0.
- NOP with valid = 1, plus code 0xD → stall never asserted, no bus activity.

Source files
------------

// File: rtl/ysyx_041461_lsu_pkg.sv
// ysyx_041461 LSU shared definitions.
// MEM control encodings, FSM states and decode helpers.
package ysyx_041461_lsu_pkg;

    localparam logic [3:0] ysyx_041461_MEM_NOP = 4'h0;
    localparam logic [3:0] ysyx_041461_MEM_LB  = 4'h1;
    localparam logic [3:0] ysyx_041461_MEM_LH  = 4'h2;
    localparam logic [3:0] ysyx_041461_MEM_LW  = 4'h3;
    localparam logic [3:0] ysyx_041461_MEM_LD  = 4'h4;
    localparam logic [3:0] ysyx_041461_MEM_LBU = 4'h5;
    localparam logic [3:0] ysyx_041461_MEM_LHU = 4'h6;
    localparam logic [3:0] ysyx_041461_MEM_LWU = 4'h7;
    localparam logic [3:0] ysyx_041461_MEM_SB  = 4'h8;
    localparam logic [3:0] ysyx_041461_MEM_SH  = 4'h9;
    localparam logic [3:0] ysyx_041461_MEM_SW  = 4'hA;
    localparam logic [3:0] ysyx_041461_MEM_SD  = 4'hB;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_REQ  = 2'd1,
        LSU_WAIT = 2'd2,
        LSU_DONE = 2'd3
    } lsu_state_e;

    function automatic logic is_mem_op(input logic [3:0] c);
        return (c != ysyx_041461_MEM_NOP) && (c <= ysyx_041461_MEM_SD);
    endfunction

    function automatic logic is_store(input logic [3:0] c);
        return (c >= ysyx_041461_MEM_SB) && (c <= ysyx_041461_MEM_SD);
    endfunction

    // log2 of the access size in bytes
    function automatic logic [1:0] mem_size(input logic [3:0] c);
        case (c)
            ysyx_041461_MEM_LH,
            ysyx_041461_MEM_LHU,
            ysyx_041461_MEM_SH:  return 2'd1;
            ysyx_041461_MEM_LW,
            ysyx_041461_MEM_LWU,
            ysyx_041461_MEM_SW:  return 2'd2;
            ysyx_041461_MEM_LD,
            ysyx_041461_MEM_SD:  return 2'd3;
            default:             return 2'd0;
        endcase
    endfunction

    function automatic logic is_misaligned(
        input logic [3:0] c,
        input logic [2:0] off
    );
        case (mem_size(c))
            2'd1:    return off[0];
            2'd2:    return |off[1:0];
            2'd3:    return |off;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ysyx_041461_lsu_align.sv
// ysyx_041461 LSU lane alignment.
// Store lane shift/strobes and load extract/extension.
module ysyx_041461_lsu_align
    import ysyx_041461_lsu_pkg::*;
(
    input  logic [3:0]  ctrl_i,
    input  logic [2:0]  off_i,
    input  logic [63:0] st_data_i,
    output logic [63:0] st_data_o,
    output logic [7:0]  st_mask_o,
    input  logic [63:0] ld_data_i,
    output logic [63:0] ld_data_o
);

    logic [7:0]  mask_base;
    logic [63:0] ld_shift;

    // Place store data and strobes on the addressed byte lanes
    always_comb begin
        st_data_o = st_data_i << {off_i, 3'b000};
        case (mem_size(ctrl_i))
            2'd0:    mask_base = 8'h01;
            2'd1:    mask_base = 8'h03;
            2'd2:    mask_base = 8'h0F;
            default: mask_base = 8'hFF;
        endcase
        st_mask_o = is_store(ctrl_i) ? (mask_base << off_i) : 8'h00;
    end

    // Bring the addressed bytes down to bit 0 and extend
    always_comb begin
        ld_shift = ld_data_i >> {off_i, 3'b000};
        case (ctrl_i)
            ysyx_041461_MEM_LB:
                ld_data_o = {{56{ld_shift[7]}}, ld_shift[7:0]};
            ysyx_041461_MEM_LH:
                ld_data_o = {{48{ld_shift[15]}}, ld_shift[15:0]};
            ysyx_041461_MEM_LW:
                ld_data_o = {{32{ld_shift[31]}}, ld_shift[31:0]};
            ysyx_041461_MEM_LD:
                ld_data_o = ld_shift;
            ysyx_041461_MEM_LBU:
                ld_data_o = {56'd0, ld_shift[7:0]};
            ysyx_041461_MEM_LHU:
                ld_data_o = {48'd0, ld_shift[15:0]};
            ysyx_041461_MEM_LWU:
                ld_data_o = {32'd0, ld_shift[31:0]};
            default:
                ld_data_o = 64'd0;
        endcase
    end

endmodule

// File: rtl/ysyx_041461_lsu.sv
// ysyx_041461 MEM-stage load/store unit.
// Holds the pipeline while one bus access runs to completion.
module ysyx_041461_lsu
    import ysyx_041461_lsu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        lsu_valid_in,
    input  logic [3:0]  lsu_ctrl_in,
    input  logic [63:0] lsu_addr_in,
    input  logic [63:0] lsu_wdata_in,
    output logic        lsu_stall_out,
    output logic        lsu_done_out,
    output logic [63:0] lsu_rdata_out,
    output logic        lsu_misalign_out,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [63:0] mem_req_addr,
    output logic        mem_req_wen,
    output logic [63:0] mem_req_wdata,
    output logic [7:0]  mem_req_wmask,
    input  logic        mem_resp_valid,
    input  logic [63:0] mem_resp_rdata
);

    lsu_state_e  state_q, state_d;
    logic [3:0]  ctrl_q, ctrl_d;
    logic [63:0] addr_q, addr_d;
    logic [63:0] wdata_q, wdata_d;
    logic [63:0] rdata_q, rdata_d;
    logic        misalign_q, misalign_d;
    logic        mem_op;
    logic [63:0] ld_data;

    assign mem_op = lsu_valid_in && is_mem_op(lsu_ctrl_in);

    ysyx_041461_lsu_align u_align (
        .ctrl_i    (ctrl_q),
        .off_i     (addr_q[2:0]),
        .st_data_i (wdata_q),
        .st_data_o (mem_req_wdata),
        .st_mask_o (mem_req_wmask),
        .ld_data_i (mem_resp_rdata),
        .ld_data_o (ld_data)
    );

    // Next-state and latch update for the access sequence
    always_comb begin
        state_d    = state_q;
        ctrl_d     = ctrl_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        misalign_d = misalign_q;
        unique case (state_q)
            LSU_IDLE: begin
                if (mem_op) begin
                    ctrl_d  = lsu_ctrl_in;
                    addr_d  = lsu_addr_in;
                    wdata_d = lsu_wdata_in;
                    rdata_d = 64'd0;
                    if (is_misaligned(lsu_ctrl_in, lsu_addr_in[2:0])) begin
                        misalign_d = 1'b1;
                        state_d    = LSU_DONE;
                    end else begin
                        misalign_d = 1'b0;
                        state_d    = LSU_REQ;
                    end
                end
            end
            LSU_REQ: begin
                if (mem_req_ready) begin
                    state_d = LSU_WAIT;
                end
            end
            LSU_WAIT: begin
                if (mem_resp_valid) begin
                    rdata_d = ld_data;
                    state_d = LSU_DONE;
                end
            end
            LSU_DONE: begin
                state_d = LSU_IDLE;
            end
        endcase
    end

    // State, latched request and result registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= LSU_IDLE;
            ctrl_q     <= ysyx_041461_MEM_NOP;
            addr_q     <= 64'd0;
            wdata_q    <= 64'd0;
            rdata_q    <= 64'd0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ctrl_q     <= ctrl_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            misalign_q <= misalign_d;
        end
    end

    assign lsu_stall_out    = mem_op && (state_q != LSU_DONE);
    assign lsu_done_out     = (state_q == LSU_DONE);
    assign lsu_rdata_out    = rdata_q;
    assign lsu_misalign_out = misalign_q;
    assign mem_req_valid    = (state_q == LSU_REQ);
    assign mem_req_addr     = {addr_q[63:3], 3'b000};
    assign mem_req_wen      = is_store(ctrl_q);

endmodule

// File: tb/tb_ysyx_041461_lsu.sv
// ysyx_041461 LSU bench.
// Cycle-timed behavioural model with random ops and bus noise.
module tb_ysyx_041461_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        lsu_valid_in;
    logic [3:0]  lsu_ctrl_in;
    logic [63:0] lsu_addr_in;
    logic [63:0] lsu_wdata_in;
    logic        lsu_stall_out;
    logic        lsu_done_out;
    logic [63:0] lsu_rdata_out;
    logic        lsu_misalign_out;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [63:0] mem_req_addr;
    logic        mem_req_wen;
    logic [63:0] mem_req_wdata;
    logic [7:0]  mem_req_wmask;
    logic        mem_resp_valid;
    logic [63:0] mem_resp_rdata;

    always #5 clk = ~clk;

    ysyx_041461_lsu dut (
        .clk              (clk),
        .rst              (rst),
        .lsu_valid_in     (lsu_valid_in),
        .lsu_ctrl_in      (lsu_ctrl_in),
        .lsu_addr_in      (lsu_addr_in),
        .lsu_wdata_in     (lsu_wdata_in),
        .lsu_stall_out    (lsu_stall_out),
        .lsu_done_out     (lsu_done_out),
        .lsu_rdata_out    (lsu_rdata_out),
        .lsu_misalign_out (lsu_misalign_out),
        .mem_req_valid    (mem_req_valid),
        .mem_req_ready    (mem_req_ready),
        .mem_req_addr     (mem_req_addr),
        .mem_req_wen      (mem_req_wen),
        .mem_req_wdata    (mem_req_wdata),
        .mem_req_wmask    (mem_req_wmask),
        .mem_resp_valid   (mem_resp_valid),
        .mem_resp_rdata   (mem_resp_rdata)
    );

    int checks = 0;
    int errors = 0;

    bit          chk_en = 0;
    bit          cur_active = 0;
    int          cur_cyc = 0;
    int          e_lat = 0;
    int          e_k = 0;
    bit          e_mis = 0;
    bit          e_store = 0;
    bit          e_load = 0;
    logic [63:0] e_addr = 0;
    logic [63:0] e_bus_wdata = 0;
    logic [7:0]  e_wmask = 0;
    logic [63:0] e_rdata = 0;

    int          stall_cnt, req_cnt, done_cyc;
    logic [63:0] last_rdata, last_req_addr, last_wdata;
    logic [7:0]  last_wmask;
    logic        last_wen, last_mis;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t",
                     nm, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] rand64();
        return {$urandom, $urandom};
    endfunction

    function automatic int m_bytes(input logic [3:0] c);
        case (c)
            4'h1, 4'h5, 4'h8: return 1;
            4'h2, 4'h6, 4'h9: return 2;
            4'h3, 4'h7, 4'hA: return 4;
            4'h4, 4'hB:       return 8;
            default:          return 0;
        endcase
    endfunction

    function automatic bit m_mis(input logic [3:0] c,
                                 input logic [63:0] a);
        return (int'(a[2:0]) % m_bytes(c)) != 0;
    endfunction

    function automatic logic [63:0] m_wdata(input logic [63:0] wd,
                                            input int off);
        logic [63:0] v = 64'd0;
        for (int i = 0; i < 8; i++)
            if (i >= off) v[8*i +: 8] = wd[8*(i-off) +: 8];
        return v;
    endfunction

    function automatic logic [7:0] m_wmask(input logic [3:0] c,
                                           input int off);
        logic [7:0] m = 8'd0;
        for (int i = 0; i < 8; i++)
            m[i] = (i >= off) && (i < off + m_bytes(c));
        return m;
    endfunction

    function automatic logic [63:0] m_load(input logic [3:0] c,
                                           input int off,
                                           input logic [63:0] rd);
        logic [63:0] v = 64'd0;
        int n = m_bytes(c);
        bit sgn = (c == 4'h1) || (c == 4'h2) || (c == 4'h3);
        for (int i = 0; i < n; i++)
            if (off + i < 8) v[8*i +: 8] = rd[8*(off+i) +: 8];
        if (sgn && v[8*n-1])
            for (int j = n; j < 8; j++) v[8*j +: 8] = 8'hFF;
        return v;
    endfunction

    // Per-cycle comparison against the model timeline
    initial forever begin
        bit xd, xr;
        @(negedge clk);
        #2;
        if (chk_en) begin
            xd = cur_active && (cur_cyc == e_lat);
            xr = cur_active && !e_mis &&
                 (cur_cyc >= 1) && (cur_cyc <= 1 + e_k);
            chk("stall", 64'(lsu_stall_out), 64'(cur_active && !xd));
            chk("done", 64'(lsu_done_out), 64'(xd));
            chk("req_valid", 64'(mem_req_valid), 64'(xr));
            if (xr) begin
                chk("req_addr", mem_req_addr,
                    {e_addr[63:3], 3'b000});
                chk("req_wen", 64'(mem_req_wen), 64'(e_store));
                if (e_store) begin
                    chk("req_wdata", mem_req_wdata, e_bus_wdata);
                    chk("req_wmask", 64'(mem_req_wmask), 64'(e_wmask));
                end
            end
            if (xd) begin
                chk("misalign", 64'(lsu_misalign_out), 64'(e_mis));
                if (e_load || e_mis)
                    chk("rdata", lsu_rdata_out, e_rdata);
            end
            if (lsu_stall_out) stall_cnt++;
            if (mem_req_valid) begin
                req_cnt++;
                last_req_addr = mem_req_addr;
                last_wdata    = mem_req_wdata;
                last_wmask    = mem_req_wmask;
                last_wen      = mem_req_wen;
            end
            if (lsu_done_out) begin
                done_cyc   = cur_cyc;
                last_rdata = lsu_rdata_out;
                last_mis   = lsu_misalign_out;
            end
        end
    end

    task automatic clr();
        stall_cnt  = 0;
        req_cnt    = 0;
        done_cyc   = -1;
        last_rdata = '1;
        last_mis   = 1'bx;
    endtask

    task automatic bus_noise();
        mem_req_ready  = 1'($urandom);
        mem_resp_valid = ($urandom_range(0, 3) == 0);
        mem_resp_rdata = rand64();
    endtask

    task automatic run_op(input logic [3:0] c, input logic [63:0] a,
                          input logic [63:0] wd, input logic [63:0] rd,
                          input int k, input int r);
        bit mis, in_req, in_wait;
        int lat;
        mis = m_mis(c, a);
        lat = mis ? 1 : k + r + 3;
        for (int cyc = 0; cyc <= lat; cyc++) begin
            @(negedge clk);
            if (cyc == 0) begin
                e_mis       = mis;
                e_lat       = lat;
                e_k         = k;
                e_addr      = a;
                e_store     = (c >= 4'h8);
                e_load      = (c < 4'h8);
                e_bus_wdata = m_wdata(wd, int'(a[2:0]));
                e_wmask     = m_wmask(c, int'(a[2:0]));
                e_rdata     = mis ? 64'd0 : m_load(c, int'(a[2:0]), rd);
            end
            cur_active   = 1;
            cur_cyc      = cyc;
            lsu_valid_in = 1'b1;
            lsu_ctrl_in  = c;
            lsu_addr_in  = a;
            lsu_wdata_in = wd;
            in_req  = !mis && cyc >= 1 && cyc <= 1 + k;
            in_wait = !mis && cyc >= k + 2 && cyc <= k + 2 + r;
            bus_noise();
            if (in_req) mem_req_ready = (cyc == 1 + k);
            if (in_wait) begin
                mem_resp_valid = (cyc == k + 2 + r);
                if (mem_resp_valid) mem_resp_rdata = rd;
            end
        end
    endtask

    task automatic run_idle(input int n, input bit fixed,
                            input logic [3:0] c);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            cur_active   = 0;
            lsu_addr_in  = rand64();
            lsu_wdata_in = rand64();
            if (fixed) begin
                lsu_valid_in = 1'b1;
                lsu_ctrl_in  = c;
            end else begin
                case ($urandom_range(0, 2))
                    0: begin
                        lsu_valid_in = 1'b0;
                        lsu_ctrl_in  = 4'($urandom);
                    end
                    1: begin
                        lsu_valid_in = 1'b1;
                        lsu_ctrl_in  = 4'h0;
                    end
                    default: begin
                        lsu_valid_in = 1'b1;
                        lsu_ctrl_in  = 4'($urandom_range(12, 15));
                    end
                endcase
            end
            bus_noise();
        end
    endtask

    initial begin
        logic [63:0] a, rd;
        logic [3:0]  c;
        rst            = 1'b0;
        lsu_valid_in   = 1'b0;
        lsu_ctrl_in    = 4'h0;
        lsu_addr_in    = 64'd0;
        lsu_wdata_in   = 64'd0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_rdata = 64'd0;
        #3;
        chk("rst_done", 64'(lsu_done_out), 64'd0);
        chk("rst_req_valid", 64'(mem_req_valid), 64'd0);
        chk("rst_misalign", 64'(lsu_misalign_out), 64'd0);
        chk("rst_rdata", lsu_rdata_out, 64'd0);
        chk("rst_addr", mem_req_addr, 64'd0);
        chk("rst_wdata", mem_req_wdata, 64'd0);
        chk("rst_wmask", 64'(mem_req_wmask), 64'd0);
        chk("rst_wen", 64'(mem_req_wen), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst    = 1'b1;
        chk_en = 1;

        rd = 64'h80AA_BBCC_DDEE_FF11;
        chk("pin_lb", m_load(4'h1, 7, rd), 64'hFFFF_FFFF_FFFF_FF80);
        chk("pin_lbu", m_load(4'h5, 7, rd), 64'h80);
        chk("pin_lh", m_load(4'h2, 2, 64'h0000_0000_8001_0000),
            64'hFFFF_FFFF_FFFF_8001);
        chk("pin_sh_wdata", m_wdata(64'hABCD, 2), 64'hABCD_0000);
        chk("pin_sh_wmask", 64'(m_wmask(4'h9, 2)), 64'h0C);
        chk("pin_lw_mis", 64'(m_mis(4'h3, 64'h8000_0006)), 64'd1);

        clr();
        run_op(4'h4, 64'h8000_0010, 64'd0, 64'h1122_3344_5566_7788, 0, 0);
        run_idle(1, 0, 4'h0);
        chk("ld_rdata", last_rdata, 64'h1122_3344_5566_7788);
        chk("ld_done_cyc", 64'(done_cyc), 64'd3);
        chk("ld_stall_cycles", 64'(stall_cnt), 64'd3);
        chk("ld_req_addr", last_req_addr, 64'h8000_0010);

        rd = {8'h80, 56'(rand64())};
        clr();
        run_op(4'h1, 64'h8000_0007, 64'd0, rd, 0, 0);
        run_idle(1, 0, 4'h0);
        chk("lb_rdata", last_rdata, 64'hFFFF_FFFF_FFFF_FF80);
        clr();
        run_op(4'h5, 64'h8000_0007, 64'd0, rd, 1, 2);
        run_idle(1, 0, 4'h0);
        chk("lbu_rdata", last_rdata, 64'h80);

        clr();
        run_op(4'h9, 64'h8000_0002, 64'hABCD, rand64(), 4, 1);
        run_idle(1, 0, 4'h0);
        chk("sh_wdata", last_wdata, 64'h0000_0000_ABCD_0000);
        chk("sh_wmask", 64'(last_wmask), 64'h0C);
        chk("sh_wen", 64'(last_wen), 64'd1);
        chk("sh_req_cycles", 64'(req_cnt), 64'd5);

        clr();
        run_op(4'h3, 64'h8000_0006, 64'd0, rand64(), 0, 0);
        run_idle(1, 0, 4'h0);
        chk("lw_mis_done_cyc", 64'(done_cyc), 64'd1);
        chk("lw_mis_req", 64'(req_cnt), 64'd0);
        chk("lw_mis_flag", 64'(last_mis), 64'd1);
        chk("lw_mis_rdata", last_rdata, 64'd0);

        clr();
        run_idle(3, 1, 4'h0);
        run_idle(3, 1, 4'hD);
        chk("nop_stall", 64'(stall_cnt), 64'd0);
        chk("nop_req", 64'(req_cnt), 64'd0);

        run_op(4'hB, 64'h8000_0100, rand64(), rand64(), 0, 0);
        run_op(4'h4, 64'h8000_0108, 64'd0, rand64(), 0, 0);

        for (int n = 0; n < 300; n++) begin
            c = 4'($urandom_range(1, 11));
            a = rand64();
            if ($urandom_range(0, 1) == 1)
                a[2:0] = 3'(int'(a[2:0]) & ~(m_bytes(c) - 1));
            run_op(c, a, rand64(), rand64(),
                   $urandom_range(0, 3), $urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1)
                run_idle($urandom_range(1, 3), 0, 4'h0);
        end
        run_idle(1, 0, 4'h0);

        chk_en     = 0;
        cur_active = 0;
        @(negedge clk);
        lsu_valid_in   = 1'b1;
        lsu_ctrl_in    = 4'h4;
        lsu_addr_in    = 64'h8000_0020;
        mem_req_ready  = 1'b1;
        mem_resp_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        mem_req_ready = 1'b0;
        #2;
        chk("pre_rst_stall", 64'(lsu_stall_out), 64'd1);
        chk("pre_rst_req", 64'(mem_req_valid), 64'd0);
        #1;
        rst = 1'b0;
        #1;
        chk("in_rst_done", 64'(lsu_done_out), 64'd0);
        @(negedge clk);
        lsu_valid_in = 1'b0;
        rst          = 1'b1;
        @(negedge clk);
        mem_resp_valid = 1'b1;
        mem_resp_rdata = rand64();
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            if (i > 0) mem_resp_valid = 1'b0;
            #2;
            chk("prst_done", 64'(lsu_done_out), 64'd0);
            chk("prst_stall", 64'(lsu_stall_out), 64'd0);
            chk("prst_req_valid", 64'(mem_req_valid), 64'd0);
            chk("prst_rdata", lsu_rdata_out, 64'd0);
            chk("prst_misalign", 64'(lsu_misalign_out), 64'd0);
            chk("prst_addr", mem_req_addr, 64'd0);
            chk("prst_wdata", mem_req_wdata, 64'd0);
            chk("prst_wmask", 64'(mem_req_wmask), 64'd0);
            chk("prst_wen", 64'(mem_req_wen), 64'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
